// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - controller word interface and SRAM pins of mem_responder
interface mem_responder_if;
  logic [14:0] addr;
  logic [31:0] fromCPU;
  logic        wRAM;
  logic        readstart;
  logic [31:0] toCPU;
  logic        readrdy;
  logic        saverdy;
  logic [15:0] sram_addr;
  logic [15:0] sram_dout;
  logic [15:0] sram_din;
  logic        sram_ce;
  logic        sram_oe;
  logic        sram_we;

  modport master (
    output addr, fromCPU, wRAM, readstart, sram_din,
    input  toCPU, readrdy, saverdy, sram_addr, sram_dout, sram_ce, sram_oe, sram_we
  );

  modport slave (
    input  addr, fromCPU, wRAM, readstart, sram_din,
    output toCPU, readrdy, saverdy, sram_addr, sram_dout, sram_ce, sram_oe, sram_we
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - 32-bit word requests served as two 16-bit async SRAM accesses
module mem_responder #(
  parameter int unsigned WAIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, RD_DONE, WR_LO, WR_HI, WR_DONE, WR_REARM
  } state_t;

  localparam logic [3:0] W = 4'(WAIT);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [14:0] r_a;
  logic [31:0] r_d;
  logic [15:0] r_lo;
  logic        r_rd_pend;
  logic [14:0] r_pend_addr;
  logic [31:0] r_to_cpu;
  logic        r_readrdy;
  logic        r_saverdy;
  logic [15:0] r_sram_addr;
  logic [15:0] r_sram_dout;
  logic        r_ce;
  logic        r_oe;
  logic        r_we;

  logic        w_last;
  logic [14:0] w_rd_addr;

  assign w_last    = (r_cnt == 4'd0);
  // a read deferred from WR_REARM uses the address captured when it arrived
  assign w_rd_addr = r_rd_pend ? r_pend_addr : bus.addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_a         <= 15'd0;
      r_d         <= 32'd0;
      r_lo        <= 16'd0;
      r_rd_pend   <= 1'b0;
      r_pend_addr <= 15'd0;
      r_to_cpu    <= 32'd0;
      r_readrdy   <= 1'b0;
      r_saverdy   <= 1'b0;
      r_sram_addr <= 16'd0;
      r_sram_dout <= 16'd0;
      r_ce        <= 1'b0;
      r_oe        <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_readrdy <= 1'b0;
      r_saverdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.readstart || r_rd_pend) begin
            r_a         <= w_rd_addr;
            r_rd_pend   <= 1'b0;
            r_cnt       <= W;
            r_ce        <= 1'b1;
            r_oe        <= 1'b1;
            r_sram_addr <= {w_rd_addr, 1'b0};
            r_state     <= RD_LO;
          end else if (bus.wRAM) begin
            r_a         <= bus.addr;
            r_d         <= bus.fromCPU;
            r_cnt       <= W;
            r_ce        <= 1'b1;
            r_we        <= 1'b1;
            r_sram_addr <= {bus.addr, 1'b0};
            r_sram_dout <= bus.fromCPU[15:0];
            r_state     <= WR_LO;
          end
        end
        RD_LO: begin
          if (w_last) begin
            r_lo        <= bus.sram_din;
            r_cnt       <= W;
            r_sram_addr <= {r_a, 1'b1};
            r_state     <= RD_HI;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RD_HI: begin
          if (w_last) begin
            r_to_cpu  <= {bus.sram_din, r_lo};
            r_readrdy <= 1'b1;
            r_ce      <= 1'b0;
            r_oe      <= 1'b0;
            r_state   <= RD_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RD_DONE: r_state <= IDLE;
        WR_LO: begin
          if (w_last) begin
            r_cnt       <= W;
            r_we        <= 1'b1;
            r_sram_addr <= {r_a, 1'b1};
            r_sram_dout <= r_d[31:16];
            r_state     <= WR_HI;
          end else begin
            // we falls one cycle before the phase ends so addr/data hold past it
            r_cnt <= r_cnt - 4'd1;
            r_we  <= (r_cnt != 4'd1);
          end
        end
        WR_HI: begin
          if (w_last) begin
            r_ce        <= 1'b0;
            r_we        <= 1'b0;
            r_sram_dout <= 16'd0;
            r_saverdy   <= 1'b1;
            r_state     <= WR_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            r_we  <= (r_cnt != 4'd1);
          end
        end
        WR_DONE: r_state <= WR_REARM;
        WR_REARM: begin
          if (bus.readstart) begin
            r_rd_pend   <= 1'b1;
            r_pend_addr <= bus.addr;
          end
          if (!bus.wRAM) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.toCPU     = r_to_cpu;
  assign bus.readrdy   = r_readrdy;
  assign bus.saverdy   = r_saverdy;
  assign bus.sram_addr = r_sram_addr;
  assign bus.sram_dout = r_sram_dout;
  assign bus.sram_ce   = r_ce;
  assign bus.sram_oe   = r_oe;
  assign bus.sram_we   = r_we;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if bus1 ();
  mem_responder_if bus15 ();

  mem_responder #(.WAIT(1))  u1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  mem_responder #(.WAIT(15)) u15 (.clk(clk), .rst(rst), .bus(bus15.slave));

  int n_cmp = 0;
  int n_err = 0;
  int wcount = 0;
  int scnt = 0;
  bit          wvalid [65536];
  logic [15:0] wmem   [65536];

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    if (wvalid[a]) return wmem[a];
    case (a)
      16'h0024: return 16'hBEEF;
      16'h0025: return 16'hDEAD;
      default:  return a ^ 16'hC3A5;
    endcase
  endfunction

  always_comb bus1.sram_din  = (bus1.sram_ce && bus1.sram_oe) ? rd_model(bus1.sram_addr) : 16'h0;
  always_comb bus15.sram_din = (bus15.sram_ce && bus15.sram_oe) ? (bus15.sram_addr ^ 16'h5A5A) : 16'h0;

  always @(negedge bus1.sram_we) begin
    if (rst && bus1.sram_ce) begin
      wmem[bus1.sram_addr]   = bus1.sram_dout;
      wvalid[bus1.sram_addr] = 1'b1;
      wcount++;
    end
  end

  always @(posedge clk) if (bus1.saverdy) scnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd1(output int n);
    n = 1;
    while (!bus1.readrdy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_sv1(output int n);
    n = 1;
    while (!bus1.saverdy && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, w0, s0, lo_n, hi_n, bad_n;
    bus1.addr = '0; bus1.fromCPU = '0; bus1.wRAM = 1'b0; bus1.readstart = 1'b0;
    bus15.addr = '0; bus15.fromCPU = '0; bus15.wRAM = 1'b0; bus15.readstart = 1'b0;

    tick(); tick();
    chk("rst_toCPU", bus1.toCPU, 32'h0);
    chk("rst_readrdy", {31'h0, bus1.readrdy}, 32'h0);
    chk("rst_saverdy", {31'h0, bus1.saverdy}, 32'h0);
    chk("rst_sram_addr", {16'h0, bus1.sram_addr}, 32'h0);
    chk("rst_ce_oe_we", {29'h0, bus1.sram_ce, bus1.sram_oe, bus1.sram_we}, 32'h0);
    rst = 1'b1;
    tick();

    // basic read, WAIT=1
    bus1.addr = 15'h0012; bus1.readstart = 1'b1;
    tick();
    bus1.readstart = 1'b0;
    wait_rd1(n);
    chk("rd_latency", n, 5);
    chk("rd_data", bus1.toCPU, 32'hDEADBEEF);
    tick();
    chk("rd_pulse_single", {31'h0, bus1.readrdy}, 32'h0);
    chk("rd_data_held", bus1.toCPU, 32'hDEADBEEF);

    // write at top address, wRAM held past saverdy
    w0 = wcount; s0 = scnt;
    bus1.addr = 15'h7FFF; bus1.fromCPU = 32'h12345678; bus1.wRAM = 1'b1;
    tick();
    wait_sv1(n);
    chk("wr_latency", n, 5);
    tick(); tick(); tick();
    chk("wr_count", wcount - w0, 2);
    chk("wr_saverdy_count", scnt - s0, 1);
    chk("wr_lo_data", {16'h0, wmem[16'hFFFE]}, 32'h5678);
    chk("wr_hi_data", {16'h0, wmem[16'hFFFF]}, 32'h1234);
    chk("wr_rearm_ce", {31'h0, bus1.sram_ce}, 32'h0);
    bus1.wRAM = 1'b0;
    tick(); tick();

    // simultaneous read and write: read served first
    w0 = wcount;
    bus1.addr = 15'h0008; bus1.fromCPU = 32'hCAFEF00D; bus1.wRAM = 1'b1; bus1.readstart = 1'b1;
    tick();
    bus1.readstart = 1'b0;
    wait_rd1(n);
    chk("both_rd_latency", n, 5);
    chk("both_rd_data", bus1.toCPU, 32'hC3B4C3B5);
    chk("both_no_write_before_rd", wcount - w0, 0);
    tick();
    wait_sv1(n);
    chk("both_wr_latency", n, 6);
    chk("both_wr_lo", {16'h0, wmem[16'h0010]}, 32'hF00D);
    chk("both_wr_hi", {16'h0, wmem[16'h0011]}, 32'hCAFE);
    bus1.wRAM = 1'b0;
    tick(); tick();

    // WAIT=15 read
    bus15.addr = 15'h0100; bus15.readstart = 1'b1;
    tick();
    bus15.readstart = 1'b0;
    n = 1; lo_n = 0; hi_n = 0; bad_n = 0;
    while (!bus15.readrdy && n < 100) begin
      if (bus15.sram_ce && bus15.sram_oe && bus15.sram_addr == 16'h0200) lo_n++;
      if (bus15.sram_ce && bus15.sram_oe && bus15.sram_addr == 16'h0201) hi_n++;
      if (bus15.sram_we || !bus15.sram_oe) bad_n++;
      tick();
      n++;
    end
    chk("w15_latency", n, 33);
    chk("w15_lo_cycles", lo_n, 16);
    chk("w15_hi_cycles", hi_n, 16);
    chk("w15_oe_we", bad_n, 0);
    chk("w15_data", bus15.toCPU, 32'h585B585A);
    tick();

    // reset asserted mid-write
    w0 = wcount; s0 = scnt;
    bus1.addr = 15'h0005; bus1.fromCPU = 32'h77778888; bus1.wRAM = 1'b1;
    tick();
    chk("mid_we_active", {31'h0, bus1.sram_we}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("mid_we_async", {31'h0, bus1.sram_we}, 32'h0);
    chk("mid_ce_oe", {30'h0, bus1.sram_ce, bus1.sram_oe}, 32'h0);
    chk("mid_sram_addr", {16'h0, bus1.sram_addr}, 32'h0);
    chk("mid_sram_dout", {16'h0, bus1.sram_dout}, 32'h0);
    chk("mid_toCPU", bus1.toCPU, 32'h0);
    bus1.wRAM = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("mid_no_saverdy", scnt - s0, 0);
    chk("mid_no_write", wcount - w0, 0);
    bus1.addr = 15'h0012; bus1.readstart = 1'b1;
    tick();
    bus1.readstart = 1'b0;
    wait_rd1(n);
    chk("mid_rd_latency", n, 5);
    chk("mid_rd_data", bus1.toCPU, 32'hDEADBEEF);
    tick();

    // back-to-back reads
    bus1.addr = 15'h0000; bus1.readstart = 1'b1;
    tick();
    bus1.readstart = 1'b0;
    wait_rd1(n);
    chk("b2b_first_data", bus1.toCPU, 32'hC3A4C3A5);
    tick();
    bus1.addr = 15'h0001; bus1.readstart = 1'b1;
    tick();
    bus1.readstart = 1'b0;
    chk("b2b_hold_before", bus1.toCPU, 32'hC3A4C3A5);
    wait_rd1(n);
    chk("b2b_second_latency", n, 5);
    chk("b2b_second_data", bus1.toCPU, 32'hC3A6C3A7);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor memory controller's word interface.
- Accepts 32-bit word read requests (`readstart` pulse) and word write requests (`wRAM` level) at a 15-bit word address.
- Serves each request from an external 16-bit asynchronous SRAM as two half-word accesses, low half then high half, with programmable wait states.
- Returns `readrdy`/`saverdy` completion pulses in the form the controller's wait states expect.

Parameters:
- WAIT, 1, extra SRAM cycles per half-word access. Legal values are 1..15; each phase lasts WAIT+1 cycles.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- addr  in  15  word address from the controller
- fromCPU  in  32  write data; [15:0] goes to the even half-word, [31:16] to the odd half-word
- wRAM  in  1  write request, held high by the controller until `saverdy`
- readstart  in  1  one-cycle read request pulse
- toCPU  out  32  read data; valid in the `readrdy` cycle, held until the next read completes
- readrdy  out  1  one-cycle read completion pulse
- saverdy  out  1  one-cycle write completion pulse
- sram_addr  out  16  half-word address: {word address, 0} for the low half, {word address, 1} for the high half
- sram_dout  out  16  write data to the SRAM
- sram_din  in  16  read data from the SRAM
- sram_ce  out  1  chip enable, active-high
- sram_oe  out  1  output enable, active-high
- sram_we  out  1  write enable, active-high

Behaviour:
- Reset values, applied asynchronously while rst=0: state IDLE; `toCPU`=0, `readrdy`=0, `saverdy`=0, `sram_addr`=0, `sram_dout`=0, `sram_ce`=0, `sram_oe`=0, `sram_we`=0; internal latches and counter = 0.
- Reset mid-operation: any in-flight request is dropped with no completion pulse. `sram_we` drops immediately, without waiting for a clock edge.
- All outputs are registered.
- States:
  - IDLE:
    - readstart=1 → latch addr → RD_LO. Read wins if both requests are present; a held `wRAM` is then served after the read completes.
    - else wRAM=1 → latch addr and fromCPU → WR_LO.
  - RD_LO:
    - Drive ce=1, oe=1, sram_addr={a,0} for WAIT+1 cycles.
    - On the last cycle, capture sram_din into data[15:0] → RD_HI.
  - RD_HI:
    - Same as RD_LO with sram_addr={a,1}; capture sram_din into data[31:16].
    - → RD_DONE.
  - RD_DONE:
    - readrdy=1 for exactly one cycle; toCPU=data in the same cycle.
    - → IDLE.
  - WR_LO:
    - Drive ce=1, sram_addr={a,0}, sram_dout=d[15:0] for WAIT+1 cycles.
    - we=1 on all but the last cycle, giving address/data hold after the we falling edge.
    - → WR_HI.
  - WR_HI:
    - Same as WR_LO with {a,1} and d[31:16].
    - → WR_DONE.
  - WR_DONE:
    - saverdy=1 for one cycle → WR_REARM.
  - WR_REARM:
    - Wait for wRAM=0 → IDLE. This prevents a still-high `wRAM` from issuing a duplicate write.
    - readstart arriving here is latched and serviced on exit to IDLE.
- Request rules outside IDLE:
  - readstart outside IDLE/WR_REARM is ignored (the controller never overlaps requests).
  - Changes to addr/fromCPU after latching have no effect.
- Idle/inactive outputs:
  - oe and we are never both 1; ce=0 in IDLE, RD_DONE, WR_DONE and WR_REARM.
  - sram_dout=0 whenever not writing.
- Latency, with readstart or write acceptance sampled at cycle 0:
  - Read: readrdy at cycle 2·WAIT+3 (5 for WAIT=1).
  - Write: saverdy at cycle 2·WAIT+3.
- Wait counter: 4-bit, reloaded to WAIT on each phase entry, phase ends at 0. WAIT=15 must not overflow.
- Address wrap: a=0x7FFF maps to sram_addr 0xFFFE/0xFFFF; no carry into other bits.

Test Plan:
- Reset, then readstart with addr=0x0012, WAIT=1; SRAM model returns 0xBEEF at 0x0024 and 0xDEAD at 0x0025 → readrdy single pulse at cycle 5, toCPU=0xDEADBEEF, held after the pulse.
- wRAM held high with addr=0x7FFF, fromCPU=0x12345678 → SRAM 0xFFFE=0x5678 and 0xFFFF=0x1234; saverdy single pulse at cycle 5; exactly one write per half even with wRAM kept high 3 extra cycles; IDLE only after wRAM=0.
- readstart and wRAM asserted in the same cycle → read completes first (readrdy), then write executes and saverdy pulses; SRAM write occurs only after readrdy.
- WAIT=15 read → readrdy at cycle 33; each sram_addr value stable for 16 cycles; oe=1 throughout, we=0.
- Assert rst=0 during WR_LO with we=1 → we=0 and all outputs at reset values without a clock edge; no saverdy pulse; after release a new read returns correct data.
- Back-to-back reads at 0x0000 then 0x0001 (second readstart the cycle after readrdy) → both accepted, toCPU updates to second word only at the second readrdy.
